// File: rtl/mips_alu_exec_if.sv
// Issue/response bundle between the EX-stage control and the ALU.
// The master drives the operation; the slave (ALU) returns results and HI/LO.
interface mips_alu_exec_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [5:0]       alu_control;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       shamt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;
   logic             invalid;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, alu_control, a, b, shamt,
      input  busy, done, result, zero, overflow, invalid, hi, lo
   );

   modport slave (
      input  start, alu_control, a, b, shamt,
      output busy, done, result, zero, overflow, invalid, hi, lo
   );
endinterface

// File: rtl/mips_alu_exec.sv
// Execute-stage ALU: registered single-cycle operations plus a 32-step
// shift-add multiplier that owns the architectural HI/LO pair.
module mips_alu_exec #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   mips_alu_exec_if.slave bus
);
   localparam int PW = 2 * WIDTH;

   localparam logic [5:0] OP_ADD   = 6'b100000;
   localparam logic [5:0] OP_ADDU  = 6'b100001;
   localparam logic [5:0] OP_SUB   = 6'b100010;
   localparam logic [5:0] OP_SUBU  = 6'b100011;
   localparam logic [5:0] OP_AND   = 6'b100100;
   localparam logic [5:0] OP_OR    = 6'b100101;
   localparam logic [5:0] OP_XOR   = 6'b100110;
   localparam logic [5:0] OP_NOR   = 6'b100111;
   localparam logic [5:0] OP_NOT   = 6'b101000;
   localparam logic [5:0] OP_SLL   = 6'b000000;
   localparam logic [5:0] OP_SRL   = 6'b000010;
   localparam logic [5:0] OP_SRA   = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b101010;
   localparam logic [5:0] OP_SLTU  = 6'b101011;
   localparam logic [5:0] OP_SEQ   = 6'b101100;
   localparam logic [5:0] OP_MFHI  = 6'b010000;
   localparam logic [5:0] OP_MFLO  = 6'b010010;
   localparam logic [5:0] OP_MULT  = 6'b011000;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_MADD  = 6'b011100;
   localparam logic [5:0] OP_MADDU = 6'b011101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic             zero_reg, zero_next;
   logic             overflow_reg, overflow_next;
   logic             invalid_reg, invalid_next;
   logic             done_reg, done_next;
   logic [PW-1:0]    acc_reg, acc_next;
   logic [PW-1:0]    mcand_reg, mcand_next;
   logic [WIDTH-1:0] mplier_reg, mplier_next;
   logic [4:0]       cnt_reg, cnt_next;
   logic             sign_reg, sign_next;
   logic             madd_reg, madd_next;

   logic [WIDTH-1:0] sum, diff, alu_res, a_mag, b_mag;
   logic             alu_ov, alu_inv, is_mul, is_madd, is_signed;
   logic [PW-1:0]    pp, prod_signed, fin_prod;

   assign sum  = bus.a + bus.b;
   assign diff = bus.a - bus.b;

   always_comb begin
      alu_res   = '0;
      alu_ov    = 1'b0;
      alu_inv   = 1'b0;
      is_mul    = 1'b0;
      is_madd   = 1'b0;
      is_signed = 1'b0;
      case (bus.alu_control)
         OP_ADD: begin
            alu_res = sum;
            alu_ov  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_ADDU: alu_res = sum;
         OP_SUB: begin
            alu_res = diff;
            alu_ov  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUBU:  alu_res = diff;
         OP_AND:   alu_res = bus.a & bus.b;
         OP_OR:    alu_res = bus.a | bus.b;
         OP_XOR:   alu_res = bus.a ^ bus.b;
         OP_NOR:   alu_res = ~(bus.a | bus.b);
         OP_NOT:   alu_res = ~bus.a;
         OP_SLL:   alu_res = bus.b << bus.shamt;
         OP_SRL:   alu_res = bus.b >> bus.shamt;
         OP_SRA:   alu_res = $unsigned($signed(bus.b) >>> bus.shamt);
         OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         OP_SEQ:   alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
         OP_MFHI:  alu_res = hi_reg;
         OP_MFLO:  alu_res = lo_reg;
         OP_MULT: begin
            is_mul    = 1'b1;
            is_signed = 1'b1;
         end
         OP_MULTU: is_mul = 1'b1;
         OP_MADD: begin
            is_mul    = 1'b1;
            is_signed = 1'b1;
            is_madd   = 1'b1;
         end
         OP_MADDU: begin
            is_mul  = 1'b1;
            is_madd = 1'b1;
         end
         default:  alu_inv = 1'b1;
      endcase
   end

   // The multiplier always works on magnitudes; the sign is restored in FIN.
   assign a_mag = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_mag = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   genvar gi;
   generate
      for (gi = 0; gi < PW; gi++) begin : g_pp
         assign pp[gi] = mcand_reg[gi] & mplier_reg[0];
      end
   endgenerate

   assign prod_signed = sign_reg ? -acc_reg : acc_reg;
   assign fin_prod    = prod_signed + (madd_reg ? {hi_reg, lo_reg} : {PW{1'b0}});

   always_comb begin
      state_next    = state_reg;
      result_next   = result_reg;
      zero_next     = zero_reg;
      overflow_next = overflow_reg;
      invalid_next  = invalid_reg;
      done_next     = 1'b0;
      hi_next       = hi_reg;
      lo_next       = lo_reg;
      acc_next      = acc_reg;
      mcand_next    = mcand_reg;
      mplier_next   = mplier_reg;
      cnt_next      = cnt_reg;
      sign_next     = sign_reg;
      madd_next     = madd_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               if (is_mul) begin
                  mcand_next  = {{WIDTH{1'b0}}, a_mag};
                  mplier_next = b_mag;
                  acc_next    = '0;
                  cnt_next    = '0;
                  sign_next   = is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  madd_next   = is_madd;
                  state_next  = MUL;
               end else begin
                  result_next   = alu_res;
                  zero_next     = (alu_res == '0);
                  overflow_next = alu_ov;
                  invalid_next  = alu_inv;
                  done_next     = 1'b1;
               end
            end
         end
         MUL: begin
            acc_next    = acc_reg + pp;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            cnt_next    = cnt_reg + 5'd1;
            if (cnt_reg == 5'd31) begin
               state_next = FIN;
            end
         end
         FIN: begin
            hi_next       = fin_prod[PW-1:WIDTH];
            lo_next       = fin_prod[WIDTH-1:0];
            result_next   = fin_prod[WIDTH-1:0];
            zero_next     = (fin_prod[WIDTH-1:0] == '0);
            overflow_next = 1'b0;
            invalid_next  = 1'b0;
            done_next     = 1'b1;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         result_reg   <= '0;
         zero_reg     <= 1'b1;
         overflow_reg <= 1'b0;
         invalid_reg  <= 1'b0;
         done_reg     <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         acc_reg      <= '0;
         mcand_reg    <= '0;
         mplier_reg   <= '0;
         cnt_reg      <= '0;
         sign_reg     <= 1'b0;
         madd_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         result_reg   <= result_next;
         zero_reg     <= zero_next;
         overflow_reg <= overflow_next;
         invalid_reg  <= invalid_next;
         done_reg     <= done_next;
         hi_reg       <= hi_next;
         lo_reg       <= lo_next;
         acc_reg      <= acc_next;
         mcand_reg    <= mcand_next;
         mplier_reg   <= mplier_next;
         cnt_reg      <= cnt_next;
         sign_reg     <= sign_next;
         madd_reg     <= madd_next;
      end
   end

   assign bus.busy     = (state_reg != IDLE);
   assign bus.done     = done_reg;
   assign bus.result   = result_reg;
   assign bus.zero     = zero_reg;
   assign bus.overflow = overflow_reg;
   assign bus.invalid  = invalid_reg;
   assign bus.hi       = hi_reg;
   assign bus.lo       = lo_reg;
endmodule

// File: doc/mips_alu_exec.md
# mips_alu_exec

Execute-stage ALU that consumes the 6-bit `alu_control` code produced by the ALU decoder and performs the operation on two 32-bit operands. It sits in EX behind the decode/control logic. Single-cycle operations return a registered result one cycle after issue. MULT/MULTU/MADD/MADDU run on an iterative shift-add multiplier that writes the architectural HI/LO pair, with a start/busy/done handshake that the pipeline uses to stall.

## Interface
- `WIDTH`, 32: operand/result width. HI/LO are each `WIDTH` bits. Only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe. Sampled only when `busy`=0.
- `alu_control`  in  6  operation code, using the decoder's encoding.
- `a`  in  32  operand A (rs).
- `b`  in  32  operand B (rt or extended immediate).
- `shamt`  in  5  shift amount for SLL/SRL/SRA.
- `busy`  out  1  a multiply is in progress; new `start` is ignored.
- `done`  out  1  one-cycle pulse: `result`/flags valid.
- `result`  out  32  registered result, held until the next `done`.
- `zero`  out  1  (`result`==0), registered with `result`.
- `overflow`  out  1  signed overflow on ADD/SUB.
- `invalid`  out  1  code not recognised.
- `hi`, `lo`  out  32 each  architectural HI/LO registers.

## Operation
- Codes and functions:
  - 100000 ADD / 100001 ADDU: a+b.
  - 100010 SUB / 100011 SUBU: a-b.
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR.
  - 101000 NOT: ~a.
  - 000000 SLL: b<<shamt. 000010 SRL: logical b>>shamt. 000011 SRA: arithmetic b>>>shamt.
  - 101010 SLT: signed, result 1/0. 101011 SLTU: unsigned, result 1/0. 101100 SEQ: (a==b), result 1/0.
  - 010000 MFHI: result=hi. 010010 MFLO: result=lo.
  - 011000 MULT, 011001 MULTU: {hi,lo}=a*b.
  - 011100 MADD, 011101 MADDU: {hi,lo}+=a*b.
- Any other code, including 111111: `result`=0, `invalid`=1, `overflow`=0, HI/LO unchanged.
- ADD/SUB: `overflow`=1 when the operand signs make the 32-bit result sign wrong. `result` is still the wrapped value; there is no trap here. ADDU/SUBU/all other ops: `overflow`=0.
- Multiply datapath:
  - Signed ops take the magnitudes of a and b and record sign = a[31]^b[31].
  - 32 iterations of a 64-bit shift-add over the unsigned magnitudes, one multiplier bit per cycle.
  - A final cycle negates the product if sign=1, then adds the old {hi,lo} for MADD/MADDU (64-bit modular add, no overflow flag), then writes {hi,lo}.
  - For multiply ops `result` = new lo.
- FSM states:
  - IDLE: on start&&!busy with a single-cycle code, register the outputs and pulse `done`; stay in IDLE. With a multiply code, latch operands, clear the accumulator and counter, go to MUL.
  - MUL: one iteration per cycle, 5-bit counter. After iteration 32 go to FIN.
  - FIN: apply sign/accumulate, write hi/lo/result, pulse `done`, go to IDLE.
- Reset (asynchronous, any state, including mid-multiply): state=IDLE; `busy`, `done`, `overflow`, `invalid`=0; `result`, `hi`, `lo`, accumulator, counter=0; `zero`=1. A multiply aborted by reset never writes HI/LO.

## Timing
- E0 = the edge at which start=1 and busy=0.
- Single-cycle ops: `result`, flags and `done`=1 are valid in the cycle after E0. `done` drops after one cycle unless another op issues at E1. Back-to-back issue every cycle is legal.
- Multiply:
  - `busy`=1 from after E0 through the cycle containing edge E33.
  - Iterations occur at E1..E32; FIN occurs at E33.
  - `hi`, `lo`, `result` and `done`=1 are valid after E33, and `busy`=0 in that same cycle.
  - Latency is 33 cycles, issue-to-done.
- `start` while busy=1 is dropped: no queueing, no side effects. The stage must stall on `busy`. A `start` at E33 itself is dropped; the next op is accepted at E34.
- MFHI/MFLO issued at E34 returns the HI/LO values written at E33.
- `hi`/`lo` change only at FIN or on reset.

## Test plan
- Reset: assert rst_n=0 mid-MULT (cycle 10) -> outputs immediately reach reset values (`busy`=0, hi=lo=0, `zero`=1). After release, MFLO returns 0.
- ALU sweep:
  - ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1.
  - ADDU same operands -> overflow=0.
  - SUB 5-5 -> result 0, zero=1.
  - SRA b=0x80000000, shamt=4 -> 0xF8000000.
  - SLTU a=1, b=0xFFFFFFFF -> 1; SLT with the same operands -> 0.
  - Each result appears one cycle after issue with `done` pulsed.
- MULT a=0xFFFFFFFE (-2), b=3 -> done 33 cycles after issue, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- MADDU a=0xFFFFFFFF, b=0xFFFFFFFF starting from hi=0, lo=1 -> hi=0xFFFFFFFE, lo=0x00000002. Follow with MFHI at the next accepted edge -> result 0xFFFFFFFE.
- Busy rule: pulse start (ADD) at cycles 5 and 33 of a multiply -> both are ignored (no `done`, result unchanged). start at E34 is accepted.
- Invalid codes 111111 and 001111 -> `done`=1, `invalid`=1, result 0, hi/lo unchanged.
